sram_req_adapter: RTL

Initiator-side adapter driving the single-port `sram` macro wrapper (1 cycle read latency, or 2 with output registers) from a valid/ready request stream. It returns read data on a valid/ready response stream. Read issue is credit-limited so that every SRAM read has a guaranteed slot in an internal response FIFO, and response back-pressure never loses data. It sits between cache/controller logic and each `sram` instance.

---
 rtl/sram_req_adapter_pkg.sv | 14 +
 rtl/sram_rsp_fifo.sv | 62 ++++++
 rtl/sram_req_adapter.sv | 93 +++++++++
 3 files changed

// File: rtl/sram_req_adapter_pkg.sv
// Width helpers shared by the SRAM request adapter and its response FIFO.
package sram_req_adapter_pkg;

  // Bits needed to hold every value in 0..n inclusive.
  function automatic int unsigned count_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index n entries, never less than one.
  function automatic int unsigned index_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Circular-buffer FIFO for SRAM read responses; registered head, no bypass path.
module sram_rsp_fifo
  import sram_req_adapter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PW = index_width(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  // Push into a full FIFO and pop from an empty one are both dropped.
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wrap_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sram_req_adapter.sv
// Valid/ready front end for a single-port SRAM with credit-limited reads.
// Both streams transfer on a cycle where valid && ready; ready never depends on valid.
module sram_req_adapter
  import sram_req_adapter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned RSP_DEPTH  = 2,
  localparam int unsigned AW  = $clog2(NUM_WORDS),
  localparam int unsigned BEW = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [AW-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [BEW-1:0]        req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [BEW-1:0]        sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam int unsigned CW = count_width(RSP_DEPTH);

  logic                accept, rd_accept;
  logic                push, pop;
  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [READ_LAT-1:0] rd_pipe_q, rd_pipe_d;

  // cnt counts reads in flight plus FIFO occupancy, so a free credit is a free slot.
  assign req_ready_o = !rst_i && (cnt_q < CW'(RSP_DEPTH));
  assign accept      = req_valid_i && req_ready_o;
  assign rd_accept   = accept && !req_we_i;

  assign sram_req_o   = accept;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  assign rsp_valid_o = !fifo_empty;
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign push        = rd_pipe_q[READ_LAT-1];

  generate
    if (READ_LAT == 1) begin : g_pipe_one
      assign rd_pipe_d = rd_accept;
    end else begin : g_pipe_multi
      assign rd_pipe_d = {rd_pipe_q[READ_LAT-2:0], rd_accept};
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q + CW'(rd_accept) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      rd_pipe_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

  sram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (sram_rdata_i),
    .pop_i       (pop),
    .pop_data_o  (rsp_rdata_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  a_no_rsp_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full));

endmodule
